// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants, count-width helper and error-cause encoding
// Used by fifo_umbral and by the central controller that decodes error causes.
package fifo_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVERFLOW,
        ERR_UNDERFLOW
    } err_cause_t;

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int af_default(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    function automatic int ae_default(input int addr_w);
        return (addr_w >= 0) ? 1 : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one write port, one registered read port
// Ports: clk, reset (sync, clears only the read register), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (updated the cycle after rd_en, held otherwise).
module fifo_mem #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    // A read to the slot being written in the same cycle returns the old contents.
    always_ff @(posedge clk)
        if (reset) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full/almost-empty thresholds
// Ports: clk, reset (sync, active-high); umbral_load/umbral_af/umbral_ae threshold load;
//        push/data_in write; pop read; data_out/valid_out registered read data (latency 1);
//        fifo_empty, fifo_full, almost_full, almost_empty, fifo_error status.
// Macro FIFO_ERR_STICKY_EN: fifo_error latches until reset instead of pulsing.
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              umbral_load,
    input  logic [ADDR_W:0]   umbral_af,
    input  logic [ADDR_W:0]   umbral_ae,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error
);

    localparam int CW = cnt_w(ADDR_W);
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_W);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] AF_RST = CW'(af_default(ADDR_W));
    localparam logic [CW-1:0] AE_RST = CW'(ae_default(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     count, af_r, ae_r;
    logic              wr_ok, rd_ok;
    err_cause_t        cause;

    // A push while full still succeeds when a pop frees the slot in the same cycle.
    assign wr_ok = push & (~fifo_full | pop);
    assign rd_ok = pop & ~fifo_empty;
    assign cause = (push & fifo_full & ~pop) ? ERR_OVERFLOW :
                   (pop & fifo_empty)        ? ERR_UNDERFLOW : ERR_NONE;

    assign fifo_empty   = count == '0;
    assign fifo_full    = count == DEPTH_C;
    assign almost_full  = count >= af_r;
    assign almost_empty = count <= ae_r;

    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            af_r       <= AF_RST;
            ae_r       <= AE_RST;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok) count <= count + ONE;
            else if (rd_ok && !wr_ok) count <= count - ONE;
            if (umbral_load) begin
                af_r <= (umbral_af > DEPTH_C) ? DEPTH_C : umbral_af;
                ae_r <= (umbral_ae > DEPTH_C) ? DEPTH_C : umbral_ae;
            end
            valid_out <= rd_ok;
`ifdef FIFO_ERR_STICKY_EN
            if (cause != ERR_NONE) fifo_error <= 1'b1;
`else
            fifo_error <= cause != ERR_NONE;
`endif
        end

    fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed plus random stimulus against a queue-based FIFO model
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       umbral_load = 1'b0;
    logic [2:0] umbral_af = '0;
    logic [2:0] umbral_ae = '0;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [5:0] data_out;
    logic       valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error;

    fifo_umbral #(.DATA_W(6), .ADDR_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .umbral_load  (umbral_load),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int d;
        bit e;
        bit f;
        bit af;
        bit ae;
        bit err;
    } exp_t;

    exp_t exq[$];
    int   mq[$];
    int   af_m = 3, ae_m = 1, last_d = 0;
    bit   err_m = 0;
    int   n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared half a cycle after the edge.
    always @(negedge clk)
        if (exq.size() > 0) begin
            exp_t x;
            x = exq.pop_front();
            chk("valid_out", 32'(valid_out), 32'(x.v));
            chk("data_out", 32'(data_out), x.d);
            chk("fifo_empty", 32'(fifo_empty), 32'(x.e));
            chk("fifo_full", 32'(fifo_full), 32'(x.f));
            chk("almost_full", 32'(almost_full), 32'(x.af));
            chk("almost_empty", 32'(almost_empty), 32'(x.ae));
            chk("fifo_error", 32'(fifo_error), 32'(x.err));
        end

    task automatic step(input bit rst, input bit ld, input int af, input int ae,
                        input bit ps, input int d, input bit pp);
        bit full, empty, rd, wr, bad, v;
        exp_t x;
        @(negedge clk);
        reset = rst; umbral_load = ld; umbral_af = 3'(af); umbral_ae = 3'(ae);
        push = ps; data_in = 6'(d); pop = pp;
        @(posedge clk);
        v = 0;
        if (rst) begin
            mq.delete(); af_m = 3; ae_m = 1; err_m = 0; last_d = 0;
        end else begin
            full  = mq.size() == 4;
            empty = mq.size() == 0;
            rd    = pp && !empty;
            wr    = ps && (!full || pp);
            bad   = (ps && full && !pp) || (pp && empty);
            if (rd) begin last_d = mq.pop_front(); v = 1; end
            if (wr) mq.push_back(d & 63);
`ifdef FIFO_ERR_STICKY_EN
            err_m = err_m || bad;
`else
            err_m = bad;
`endif
            if (ld) begin
                af_m = ((af & 7) > 4) ? 4 : (af & 7);
                ae_m = ((ae & 7) > 4) ? 4 : (ae & 7);
            end
        end
        x = '{v: v, d: last_d, e: mq.size() == 0, f: mq.size() == 4,
              af: mq.size() >= af_m, ae: mq.size() <= ae_m, err: err_m};
        exq.push_back(x);
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input int d);   step(0, 0, 0, 0, 1, d, 0); endtask
    task automatic rd();              step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic both(input int d); step(0, 0, 0, 0, 1, d, 1); endtask
    task automatic rst_c();           step(1, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        rst_c(); idle(); idle();
        for (int i = 1; i <= 4; i++) wr(i);
        for (int i = 0; i < 4; i++) rd();
        idle();
        step(0, 1, 2, 0, 0, 0, 0);
        wr(7); wr(8); rd(); rd(); idle();
        for (int i = 1; i <= 4; i++) wr(i);
        wr(6'h3F); idle(); idle();
        for (int i = 0; i < 4; i++) rd();
        rst_c();
        for (int i = 1; i <= 4; i++) wr(i);
        both(6'h2A); idle();
        for (int i = 0; i < 4; i++) rd();
        rst_c();
        both(6'h15); idle(); rd(); idle();
        wr(1); wr(2); wr(3); rst_c(); idle(); rd();
        step(0, 1, 7, 6, 0, 0, 0);
        for (int i = 1; i <= 5; i++) wr(i);
        rst_c();
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r == 0, $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);
        end
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Parameterised synchronous FIFO that answers the central control FSM.
- Accepts programmable almost-full/almost-empty thresholds, loaded while the controller sits in INIT.
- Reports empty, full, almost-full, almost-empty and overflow/underflow error back to the controller.
- One instance per traffic class; instance flags are concatenated into the controller's per-FIFO empty/error buses.

Parameters:
- DATA_W, 6, payload width in bits.
- ADDR_W, 2, address width; depth DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- umbral_load  in  1  load thresholds this cycle (controller asserts in INIT).
- umbral_af  in  ADDR_W+1  almost-full threshold.
- umbral_ae  in  ADDR_W+1  almost-empty threshold.
- push  in  1  write request.
- data_in  in  DATA_W  write data.
- pop  in  1  read request.
- data_out  out  DATA_W  registered read data.
- valid_out  out  1  data_out valid this cycle.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_full  out  1  count >= af threshold.
- almost_empty  out  1  count <= ae threshold.
- fifo_error  out  1  overflow/underflow indication.

Behaviour:
- Reset (sync, high):
  - wr_ptr, rd_ptr and count = 0; data_out = 0; valid_out = 0; fifo_error = 0.
  - Thresholds: af = DEPTH-1, ae = 1.
  - Resulting flags: fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0.
  - Reset mid-operation discards contents; memory array itself is not cleared.
- Threshold load:
  - When umbral_load = 1, register umbral_af/umbral_ae.
  - The new values are used in flag compares from the next cycle.
  - Load concurrent with push/pop is legal.
  - Values > DEPTH are saturated to DEPTH.
- Write: push & !fifo_full stores data_in at wr_ptr; wr_ptr wraps mod DEPTH.
- Read:
  - pop & !fifo_empty makes data_out = mem[rd_ptr] and valid_out = 1 on the next cycle (latency 1); rd_ptr wraps mod DEPTH.
  - valid_out = 0 on any cycle without a successful pop.
  - data_out holds its last value when idle.
- count:
  - Width ADDR_W+1.
  - +1 on successful write only, -1 on successful read only, unchanged when both succeed.
- Simultaneous push & pop:
  - When full: both succeed, count stays DEPTH.
  - When empty: the pop is an underflow; the push succeeds (no bypass), so count becomes 1.
- Errors:
  - push & fifo_full & !pop is overflow; data is dropped, pointers unchanged.
  - pop & fifo_empty is underflow; pointers unchanged, valid_out = 0.
  - Either raises fifo_error on the next cycle.
- Flags: all derived from registered count and thresholds (no combinational path from push/pop).

Optional Feature:
- Macro FIFO_ERR_STICKY_EN.
- Defined: fifo_error latches at 1 after the first overflow/underflow and clears only on reset; the controller's ERROR state depends on this.
- Undefined: fifo_error is a single-cycle pulse per offending request.
- All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - default threshold constants (AF_DEFAULT = DEPTH-1, AE_DEFAULT = 1) as functions of ADDR_W;
  - the count-width helper;
  - the error-cause encoding (NONE, OVERFLOW, UNDERFLOW), reused by the controller.
- One sub-module: fifo_mem, a DEPTH x DATA_W register array with one write port and one registered read port.
- Pointer, count, flag and threshold logic stay in fifo_umbral.

Test Plan (DATA_W=6, ADDR_W=2, DEPTH=4):
- Reset, then idle: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, fifo_error=0, valid_out=0.
- Push 0x01..0x04 on 4 consecutive cycles, then pop 4: fifo_full=1 after the 4th write; data_out=0x01..0x04 each one cycle after its pop; fifo_empty=1 at end.
- Load af=2, ae=0, then push 2: almost_full=1 when count=2; almost_empty=1 only at count 0.
- Fill to 4, push 0x3F without pop: fifo_error=1 next cycle, count stays 4; popping 4 returns 0x01..0x04, 0x3F absent.
  - With FIFO_ERR_STICKY_EN: error stays 1.
  - Without: error is a 1-cycle pulse.
- Full and simultaneous push 0x2A / pop: no error, count=4; data_out = oldest entry; 0x2A is read last.
- Empty and simultaneous push 0x15 / pop: underflow error, valid_out=0, count=1; the next pop returns 0x15.
- Assert reset with count=3: next cycle count=0, fifo_empty=1, fifo_error=0, thresholds back to 3/1.
